// File: rtl/stream_merge_arb.sv
// Packet-atomic 2:1 AXI-Stream merger with round-robin tie-break, one registered
// output stage with full backpressure, and per-input completed-packet counters.
module stream_merge_arb #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 137,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,

  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,

  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;

  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;

  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

  logic                  out_free_c;
  logic                  s0_rdy_c, s1_rdy_c;
  logic                  acc0_c, acc1_c;

  // Arbitration, packet lock, output-stage load/drain and counters.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tuser_d      = tuser_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    s0_rdy_c     = 1'b0;
    s1_rdy_c     = 1'b0;

    out_free_c   = !tvalid_q || m_axis_tready;

    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          // Tie goes to whichever input did not win last time.
          if (last_grant_q) begin
            state_d      = PASS0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = PASS1;
            last_grant_d = 1'b1;
          end
        end else if (s0_axis_tvalid) begin
          state_d      = PASS0;
          last_grant_d = 1'b0;
        end else if (s1_axis_tvalid) begin
          state_d      = PASS1;
          last_grant_d = 1'b1;
        end
      end
      PASS0:   s0_rdy_c = out_free_c;
      PASS1:   s1_rdy_c = out_free_c;
      default: state_d = IDLE;
    endcase

    acc0_c = s0_axis_tvalid && s0_rdy_c;
    acc1_c = s1_axis_tvalid && s1_rdy_c;

    if (acc0_c) begin
      tdata_d  = s0_axis_tdata;
      tkeep_d  = s0_axis_tkeep;
      tuser_d  = s0_axis_tuser;
      tlast_d  = s0_axis_tlast;
      tvalid_d = 1'b1;
      if (s0_axis_tlast) begin
        state_d = IDLE;
        cnt0_d  = cnt0_q + CNT_WIDTH'(1);
      end
    end else if (acc1_c) begin
      tdata_d  = s1_axis_tdata;
      tkeep_d  = s1_axis_tkeep;
      tuser_d  = s1_axis_tuser;
      tlast_d  = s1_axis_tlast;
      tvalid_d = 1'b1;
      if (s1_axis_tlast) begin
        state_d = IDLE;
        cnt1_d  = cnt1_q + CNT_WIDTH'(1);
      end
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // State, output stage and counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tuser_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  // Ready is combinational so a downstream stall blocks the granted input the same cycle.
  assign s0_axis_tready = s0_rdy_c;
  assign s1_axis_tready = s1_rdy_c;

  assign m_axis_tdata   = tdata_q;
  assign m_axis_tkeep   = tkeep_q;
  assign m_axis_tuser   = tuser_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tvalid  = tvalid_q;

  assign pkt_cnt0       = cnt0_q;
  assign pkt_cnt1       = cnt1_q;

endmodule

// File: tb/tb_stream_merge_arb.sv
// Directed bench for stream_merge_arb: a cycle table for the basic handshake,
// then queue-driven sequences for fairness, backpressure, lock, reset and wrap.
module tb_stream_merge_arb;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;
  localparam int unsigned UW = 137;
  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] s0_axis_tdata,  s1_axis_tdata,  m_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep,  s1_axis_tkeep,  m_axis_tkeep;
  logic [UW-1:0] s0_axis_tuser,  s1_axis_tuser,  m_axis_tuser;
  logic          s0_axis_tlast,  s1_axis_tlast,  m_axis_tlast;
  logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  always #5 CLK = ~CLK;

  stream_merge_arb #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tuser(s0_axis_tuser), .s0_axis_tlast(s0_axis_tlast),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tuser(s1_axis_tuser), .s1_axis_tlast(s1_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         cyc;
  } cap_t;

  typedef struct {
    logic       s0v, s0l;
    logic [7:0] s0d;
    logic       s1v, s1l;
    logic [7:0] s1d;
    logic       mr;
    logic       e_r0, e_r1, e_mv, e_ml;
    logic [7:0] e_md;
    logic [3:0] e_c0, e_c1;
  } vec_t;

  int checks = 0;
  int errors = 0;

  beat_t         q0[$], q1[$], exp_q[$];
  cap_t          cap[$];
  int            cyc, n0, gap_at, gap_left;
  logic          done0, chk_lock, prev_stall;
  logic [DW-1:0] prev_d;
  vec_t          tbl[13];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_s0(input logic v, input logic l, input logic [7:0] d);
    s0_axis_tvalid = v;
    s0_axis_tlast  = l;
    s0_axis_tdata  = DW'(d);
    s0_axis_tkeep  = KW'(d);
    s0_axis_tuser  = UW'(d);
  endtask

  task automatic set_s1(input logic v, input logic l, input logic [7:0] d);
    s1_axis_tvalid = v;
    s1_axis_tlast  = l;
    s1_axis_tdata  = DW'(d);
    s1_axis_tkeep  = KW'(d);
    s1_axis_tuser  = UW'(d);
  endtask

  task automatic drive();
    if (q0.size() > 0 && gap_left == 0) set_s0(1'b1, q0[0].l, q0[0].d);
    else set_s0(1'b0, 1'b0, 8'h00);
    if (gap_left > 0) gap_left--;
    if (q1.size() > 0) set_s1(1'b1, q1[0].l, q1[0].d);
    else set_s1(1'b0, 1'b0, 8'h00);
  endtask

  // One cycle: observe at negedge, then advance the source queues past the edge.
  task automatic tick();
    logic acc0, acc1;
    @(negedge CLK);
    acc0 = s0_axis_tvalid && s0_axis_tready;
    acc1 = s1_axis_tvalid && s1_axis_tready;
    if (m_axis_tvalid && m_axis_tready) cap.push_back('{m_axis_tdata[7:0], m_axis_tlast, cyc});
    if (prev_stall) begin
      chk("stall_valid_held", DW'(m_axis_tvalid), DW'(1'b1));
      chk("stall_data_held", m_axis_tdata, prev_d);
    end
    if (m_axis_tvalid && !m_axis_tready) begin
      chk("stall_s0_tready", DW'(s0_axis_tready), DW'(1'b0));
      chk("stall_s1_tready", DW'(s1_axis_tready), DW'(1'b0));
      prev_stall = 1'b1;
      prev_d     = m_axis_tdata;
    end else begin
      prev_stall = 1'b0;
    end
    if (chk_lock && !done0) chk("lock_s1_tready", DW'(s1_axis_tready), DW'(1'b0));
    @(posedge CLK);
    #1;
    cyc++;
    if (acc0) begin
      if (q0[0].l) done0 = 1'b1;
      void'(q0.pop_front());
      n0++;
      if (n0 == gap_at) gap_left = 2;
    end
    if (acc1) void'(q1.pop_front());
    drive();
  endtask

  task automatic clear_state();
    q0.delete(); q1.delete(); exp_q.delete(); cap.delete();
    cyc = 0; n0 = 0; gap_at = 0; gap_left = 0;
    done0 = 1'b0; chk_lock = 1'b0; prev_stall = 1'b0; prev_d = '0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    clear_state();
    set_s0(1'b0, 1'b0, 8'h00);
    set_s1(1'b0, 1'b0, 8'h00);
    m_axis_tready = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // mode 0: order only; 1: plus one bubble between packets; 2: plus back-to-back within packets.
  task automatic check_out(input string name, input int mode);
    int n;
    chk({name, "_count"}, DW'(cap.size()), DW'(exp_q.size()));
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_data"}, DW'(cap[i].d), DW'(exp_q[i].d));
      chk({name, "_last"}, DW'(cap[i].l), DW'(exp_q[i].l));
      if (i > 0 && mode >= 1 && cap[i-1].l)
        chk({name, "_bubble"}, DW'(cap[i].cyc - cap[i-1].cyc), DW'(2));
      if (i > 0 && mode == 2 && !cap[i-1].l)
        chk({name, "_b2b"}, DW'(cap[i].cyc - cap[i-1].cyc), DW'(1));
    end
  endtask

  initial begin
    int k;
    logic [7:0] bp_pat [9];

    //            s0v s0l s0d    s1v s1l s1d    mr   r0 r1 mv ml md     c0    c1
    tbl[0]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1, 1'b0,1'b0,1'b0,1'b0,8'h00,4'd0,4'd0};
    tbl[1]  = '{1'b1,1'b0,8'hA1, 1'b0,1'b0,8'h00, 1'b1, 1'b0,1'b0,1'b0,1'b0,8'h00,4'd0,4'd0};
    tbl[2]  = '{1'b1,1'b0,8'hA1, 1'b0,1'b0,8'h00, 1'b1, 1'b1,1'b0,1'b0,1'b0,8'h00,4'd0,4'd0};
    tbl[3]  = '{1'b1,1'b0,8'hA2, 1'b0,1'b0,8'h00, 1'b1, 1'b1,1'b0,1'b1,1'b0,8'hA1,4'd0,4'd0};
    tbl[4]  = '{1'b1,1'b1,8'hA3, 1'b0,1'b0,8'h00, 1'b1, 1'b1,1'b0,1'b1,1'b0,8'hA2,4'd0,4'd0};
    tbl[5]  = '{1'b1,1'b1,8'hB0, 1'b1,1'b1,8'hC0, 1'b1, 1'b0,1'b0,1'b1,1'b1,8'hA3,4'd1,4'd0};
    tbl[6]  = '{1'b1,1'b1,8'hB0, 1'b1,1'b1,8'hC0, 1'b1, 1'b0,1'b1,1'b0,1'b0,8'h00,4'd1,4'd0};
    tbl[7]  = '{1'b1,1'b1,8'hB0, 1'b0,1'b0,8'h00, 1'b1, 1'b0,1'b0,1'b1,1'b1,8'hC0,4'd1,4'd1};
    tbl[8]  = '{1'b1,1'b1,8'hB0, 1'b0,1'b0,8'h00, 1'b0, 1'b1,1'b0,1'b0,1'b0,8'h00,4'd1,4'd1};
    tbl[9]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0, 1'b0,1'b0,1'b1,1'b1,8'hB0,4'd2,4'd1};
    tbl[10] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0, 1'b0,1'b0,1'b1,1'b1,8'hB0,4'd2,4'd1};
    tbl[11] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1, 1'b0,1'b0,1'b1,1'b1,8'hB0,4'd2,4'd1};
    tbl[12] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1, 1'b0,1'b0,1'b0,1'b0,8'h00,4'd2,4'd1};

    do_reset();
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tkeep", DW'(m_axis_tkeep), '0);
    chk("rst_tuser", DW'(m_axis_tuser), '0);
    chk("rst_tlast", DW'(m_axis_tlast), '0);

    // Single packet, tie-break, and a one-beat packet held under backpressure.
    for (int i = 0; i < 13; i++) begin
      set_s0(tbl[i].s0v, tbl[i].s0l, tbl[i].s0d);
      set_s1(tbl[i].s1v, tbl[i].s1l, tbl[i].s1d);
      m_axis_tready = tbl[i].mr;
      @(negedge CLK);
      chk($sformatf("tbl%0d_s0_tready", i), DW'(s0_axis_tready), DW'(tbl[i].e_r0));
      chk($sformatf("tbl%0d_s1_tready", i), DW'(s1_axis_tready), DW'(tbl[i].e_r1));
      chk($sformatf("tbl%0d_m_tvalid", i), DW'(m_axis_tvalid), DW'(tbl[i].e_mv));
      chk($sformatf("tbl%0d_pkt_cnt0", i), DW'(pkt_cnt0), DW'(tbl[i].e_c0));
      chk($sformatf("tbl%0d_pkt_cnt1", i), DW'(pkt_cnt1), DW'(tbl[i].e_c1));
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d_m_tdata", i), m_axis_tdata, DW'(tbl[i].e_md));
        chk($sformatf("tbl%0d_m_tkeep", i), DW'(m_axis_tkeep), DW'(tbl[i].e_md));
        chk($sformatf("tbl%0d_m_tuser", i), DW'(m_axis_tuser), DW'(tbl[i].e_md));
        chk($sformatf("tbl%0d_m_tlast", i), DW'(m_axis_tlast), DW'(tbl[i].e_ml));
      end
      @(posedge CLK);
      #1;
    end

    // Fairness: both inputs continuously offer 2-beat packets.
    do_reset();
    q0 = '{'{8'h10, 1'b0}, '{8'h11, 1'b1}, '{8'h12, 1'b0}, '{8'h13, 1'b1}};
    q1 = '{'{8'h20, 1'b0}, '{8'h21, 1'b1}, '{8'h22, 1'b0}, '{8'h23, 1'b1}};
    exp_q = '{'{8'h10, 1'b0}, '{8'h11, 1'b1}, '{8'h20, 1'b0}, '{8'h21, 1'b1},
              '{8'h12, 1'b0}, '{8'h13, 1'b1}, '{8'h22, 1'b0}, '{8'h23, 1'b1}};
    drive();
    repeat (25) tick();
    check_out("fair", 2);
    chk("fair_pkt_cnt0", DW'(pkt_cnt0), DW'(2));
    chk("fair_pkt_cnt1", DW'(pkt_cnt1), DW'(2));

    // Reset in the middle of a 5-beat s0 packet; counters are non-zero going in.
    cap.delete(); n0 = 0;
    for (int i = 0; i < 5; i++) q0.push_back('{8'(8'h60 + i), i == 4});
    drive();
    k = 0;
    while (n0 < 2 && k < 20) begin
      tick();
      k++;
    end
    chk("rstmid_reach_beat2", DW'(n0), DW'(2));
    #2;
    RST = 1'b0;
    #1;
    chk("rstmid_m_tvalid", DW'(m_axis_tvalid), '0);
    chk("rstmid_m_tlast", DW'(m_axis_tlast), '0);
    chk("rstmid_m_tdata", m_axis_tdata, '0);
    chk("rstmid_s0_tready", DW'(s0_axis_tready), '0);
    chk("rstmid_s1_tready", DW'(s1_axis_tready), '0);
    chk("rstmid_pkt_cnt0", DW'(pkt_cnt0), '0);
    chk("rstmid_pkt_cnt1", DW'(pkt_cnt1), '0);
    clear_state();
    drive();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    q1 = '{'{8'h70, 1'b0}, '{8'h71, 1'b1}};
    exp_q = q1;
    drive();
    repeat (10) tick();
    check_out("rstmid_after", 1);
    chk("rstmid_after_cnt0", DW'(pkt_cnt0), DW'(0));
    chk("rstmid_after_cnt1", DW'(pkt_cnt1), DW'(1));

    // Backpressure on a 4-beat s1 packet.
    do_reset();
    bp_pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1};
    q1 = '{'{8'h30, 1'b0}, '{8'h31, 1'b0}, '{8'h32, 1'b0}, '{8'h33, 1'b1}};
    exp_q = q1;
    drive();
    for (int i = 0; i < 9; i++) begin
      m_axis_tready = bp_pat[i][0];
      tick();
    end
    m_axis_tready = 1'b1;
    repeat (4) tick();
    check_out("bp", 0);
    chk("bp_pkt_cnt1", DW'(pkt_cnt1), DW'(1));

    // No interleave: s0 stalls its own valid mid-packet while s1 waits.
    do_reset();
    q0 = '{'{8'h40, 1'b0}, '{8'h41, 1'b0}, '{8'h42, 1'b0}, '{8'h43, 1'b1}};
    q1 = '{'{8'h50, 1'b0}, '{8'h51, 1'b1}};
    exp_q = '{'{8'h40, 1'b0}, '{8'h41, 1'b0}, '{8'h42, 1'b0}, '{8'h43, 1'b1},
              '{8'h50, 1'b0}, '{8'h51, 1'b1}};
    gap_at = 2;
    chk_lock = 1'b1;
    drive();
    repeat (16) tick();
    check_out("lock", 1);
    chk("lock_pkt_cnt0", DW'(pkt_cnt0), DW'(1));
    chk("lock_pkt_cnt1", DW'(pkt_cnt1), DW'(1));

    // Counter wrap: 17 single-beat packets into a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      q0.push_back('{8'(8'h80 + i), 1'b1});
      exp_q.push_back('{8'(8'h80 + i), 1'b1});
    end
    drive();
    repeat (40) tick();
    check_out("wrap", 1);
    chk("wrap_pkt_cnt0", DW'(pkt_cnt0), DW'(1));
    chk("wrap_pkt_cnt1", DW'(pkt_cnt1), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
